branch_sequencer: RTL and testbench

Multi-cycle fetch/branch sequencer for the KGP RISC core. Owns the program counter and the latched ALU flags register, and fetches each instruction from instruction memory with a request/valid handshake. It issues the instruction to the decode/execute datapath, waits for execute completion, then resolves the branch condition and selects the next PC. It also produces the link-register write for `bl` and stops the core on the halt opcode.

---
 rtl/branch_sequencer.sv | 162 ++++++++++++++++
 tb/tb_branch_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_sequencer.sv
// rtl/branch_sequencer.sv - multi-cycle fetch/branch sequencer owning the PC and latched ALU flags
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   imem_addr/req          fetch address (current PC) and request (FETCH only)
//   imem_valid/data        instruction memory response, sampled only in FETCH
//   instr/instr_valid      latched instruction and one-cycle issue strobe
//   exec_done, flag_we     execute completion and flag load enable (WAIT_EXEC only)
//   alu_sign/carry/zero    ALU status flags
//   rs_value               register operand used as the br target
//   link_we/link_data      $31 write strobe and PC+4 of the bl instruction
//   halted                 high while parked in HALT
//   retired                count of resolved instructions
module branch_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic        imem_valid,
    input  logic [31:0] imem_data,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        exec_done,
    input  logic        flag_we,
    input  logic        alu_sign,
    input  logic        alu_carry,
    input  logic        alu_zero,
    input  logic [31:0] rs_value,
    output logic        link_we,
    output logic [31:0] link_data,
    output logic        halted,
    output logic [31:0] retired
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FETCH     = 3'd1;
    localparam logic [2:0] S_ISSUE     = 3'd2;
    localparam logic [2:0] S_WAIT_EXEC = 3'd3;
    localparam logic [2:0] S_RESOLVE   = 3'd4;
    localparam logic [2:0] S_HALT      = 3'd5;

    localparam logic [5:0] OP_BLTZ = 6'b000111;
    localparam logic [5:0] OP_BZ   = 6'b001000;
    localparam logic [5:0] OP_BNZ  = 6'b001001;
    localparam logic [5:0] OP_BR   = 6'b001010;
    localparam logic [5:0] OP_B    = 6'b001011;
    localparam logic [5:0] OP_BL   = 6'b001100;
    localparam logic [5:0] OP_BCY  = 6'b001101;
    localparam logic [5:0] OP_BNCY = 6'b001110;

    logic [2:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] retired_q, retired_d;
    logic        flag_s_q, flag_s_d;
    logic        flag_c_q, flag_c_d;
    logic        flag_z_q, flag_z_d;

    logic [5:0]  opcode;
    logic [31:0] pc_plus4;
    logic [31:0] imm_target;
    logic        taken;
    logic [31:0] target;

    assign opcode     = instr_q[31:26];
    assign pc_plus4   = pc_q + 32'd4;
    assign imm_target = {4'b0000, instr_q[25:0], 2'b00};
    assign target     = (opcode == OP_BR) ? rs_value : imm_target;

    // Conditions read the latched flags, never the live ALU inputs, so a
    // carry set by an earlier instruction is still visible to bcy/bncy.
    always_comb begin
        taken = 1'b0;
        case (opcode)
            OP_BLTZ: taken = flag_s_q && !flag_z_q;
            OP_BZ:   taken = !flag_s_q && flag_z_q;
            OP_BNZ:  taken = !flag_z_q;
            OP_BR:   taken = 1'b1;
            OP_B:    taken = 1'b1;
            OP_BL:   taken = 1'b1;
            OP_BCY:  taken = flag_c_q;
            OP_BNCY: taken = !flag_c_q;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        retired_d = retired_q;
        flag_s_d  = flag_s_q;
        flag_c_d  = flag_c_q;
        flag_z_d  = flag_z_q;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (imem_valid) begin
                    instr_d = imem_data;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_WAIT_EXEC;
            S_WAIT_EXEC: begin
                if (exec_done) begin
                    if (flag_we) begin
                        flag_s_d = alu_sign;
                        flag_c_d = alu_carry;
                        flag_z_d = alu_zero;
                    end
                    state_d = S_RESOLVE;
                end
            end
            S_RESOLVE: begin
                if (opcode == HALT_OPCODE) begin
                    state_d = S_HALT;
                end else begin
                    pc_d      = taken ? target : pc_plus4;
                    retired_d = retired_q + 32'd1;
                    state_d   = S_FETCH;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            instr_q   <= 32'd0;
            retired_q <= 32'd0;
            flag_s_q  <= 1'b0;
            flag_c_q  <= 1'b0;
            flag_z_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            retired_q <= retired_d;
            flag_s_q  <= flag_s_d;
            flag_c_q  <= flag_c_d;
            flag_z_q  <= flag_z_d;
        end
    end

    // All outputs come from registered state, so no input reaches an output
    // combinationally. link_data is pc+4 while the PC still holds the bl address.
    assign imem_addr   = pc_q;
    assign imem_req    = (state_q == S_FETCH);
    assign instr       = instr_q;
    assign instr_valid = (state_q == S_ISSUE);
    assign link_we     = (state_q == S_RESOLVE) && (opcode == OP_BL) && (opcode != HALT_OPCODE);
    assign link_data   = pc_plus4;
    assign halted      = (state_q == S_HALT);
    assign retired     = retired_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// tb/tb_branch_sequencer.sv - scoreboard bench for branch_sequencer
module tb_branch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic        imem_valid;
    logic [31:0] imem_data;
    logic [31:0] instr;
    logic        instr_valid;
    logic        exec_done;
    logic        flag_we;
    logic        alu_sign;
    logic        alu_carry;
    logic        alu_zero;
    logic [31:0] rs_value;
    logic        link_we;
    logic [31:0] link_data;
    logic        halted;
    logic [31:0] retired;

    always #5 clk = ~clk;

    branch_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .imem_addr  (imem_addr),
        .imem_req   (imem_req),
        .imem_valid (imem_valid),
        .imem_data  (imem_data),
        .instr      (instr),
        .instr_valid(instr_valid),
        .exec_done  (exec_done),
        .flag_we    (flag_we),
        .alu_sign   (alu_sign),
        .alu_carry  (alu_carry),
        .alu_zero   (alu_zero),
        .rs_value   (rs_value),
        .link_we    (link_we),
        .link_data  (link_data),
        .halted     (halted),
        .retired    (retired)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] ret;
        int          gap;
    } fetch_t;

    fetch_t      fq[$];
    logic [31:0] iq[$];
    logic [31:0] lq[$];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a fetch, issue or link write.
    fetch_t cur;
    logic   prev_req = 1'b0;
    int     cyc = 0;
    int     last_fetch_cyc = 0;

    always @(negedge clk) begin
        cyc++;
        if (imem_req === 1'b1) begin
            if (prev_req !== 1'b1) begin
                if (fq.size() == 0) begin
                    chk("fetch_unexpected", imem_addr, 32'hFFFF_FFFF);
                    cur.addr = imem_addr;
                    cur.ret  = retired;
                    cur.gap  = 0;
                end else begin
                    cur = fq.pop_front();
                    chk("retired_at_fetch", retired, cur.ret);
                    if (cur.gap != 0)
                        chk("fetch_gap", 32'(cyc - last_fetch_cyc), 32'(cur.gap));
                end
                last_fetch_cyc = cyc;
            end
            chk("imem_addr", imem_addr, cur.addr);
        end
        prev_req = imem_req;
        if (instr_valid === 1'b1) begin
            chk("issue_no_link", {31'd0, link_we}, 32'd0);
            if (iq.size() == 0) chk("issue_unexpected", instr, 32'hFFFF_FFFF);
            else chk("instr", instr, iq.pop_front());
        end
        if (link_we === 1'b1) begin
            if (lq.size() == 0) chk("link_unexpected", link_data, 32'hFFFF_FFFF);
            else chk("link_data", link_data, lq.pop_front());
        end
    end

    task automatic wait_req();
        int n = 0;
        while (imem_req !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (imem_req !== 1'b1) chk("req_timeout", {31'd0, imem_req}, 32'd1);
    endtask

    task automatic fetch_issue(input logic [31:0] addr, input logic [31:0] ret, input int gap,
                               input logic [31:0] data, input int stall);
        fetch_t f;
        f.addr = addr; f.ret = ret; f.gap = gap;
        fq.push_back(f);
        iq.push_back(data);
        wait_req();
        repeat (stall) begin
            @(posedge clk); #1;
        end
        imem_valid = 1'b1;
        imem_data  = data;
        @(posedge clk); #1;
        imem_valid = 1'b0;
        imem_data  = 32'hDEAD_BEEF;
        @(posedge clk); #1;
    endtask

    task automatic run_instr(input logic [31:0] addr, input logic [31:0] ret, input int gap,
                             input logic [31:0] data, input logic fwe, input logic s,
                             input logic c, input logic z, input logic [31:0] rs,
                             input int stall, input logic lv, input logic [31:0] lexp);
        if (lv) lq.push_back(lexp);
        fetch_issue(addr, ret, gap, data, stall);
        exec_done = 1'b1;
        flag_we   = fwe;
        alu_sign  = s;
        alu_carry = c;
        alu_zero  = z;
        rs_value  = rs;
        @(posedge clk); #1;
        exec_done = 1'b0;
        flag_we   = 1'b0;
        alu_sign  = 1'b1;
        alu_carry = 1'b1;
        alu_zero  = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        fetch_t f;
        rst = 1'b1; imem_valid = 1'b0; imem_data = 32'd0; exec_done = 1'b0;
        flag_we = 1'b0; alu_sign = 1'b0; alu_carry = 1'b0; alu_zero = 1'b0; rs_value = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
        chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_link_we", {31'd0, link_we}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_retired", retired, 32'd0);
        chk("rst_imem_addr", imem_addr, 32'd0);
        chk("rst_instr", instr, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        // addr, retired, gap, word, flag_we, S, C, Z, rs, stall, link?, link_data
        run_instr(32'h000, 32'd0,  0, 32'h0000_0042, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 0, 1'b0, 32'h0);
        run_instr(32'h004, 32'd1,  4, 32'h0400_0123, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 0, 1'b0, 32'h0);
        run_instr(32'h008, 32'd2,  4, 32'h0400_0456, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 0, 1'b0, 32'h0);
        run_instr(32'h00C, 32'd3,  4, 32'h2000_0010, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 0, 1'b0, 32'h0);
        run_instr(32'h040, 32'd4,  4, 32'h2000_0010, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 0, 1'b0, 32'h0);
        run_instr(32'h044, 32'd5,  4, 32'h1C00_0020, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 0, 1'b0, 32'h0);
        run_instr(32'h080, 32'd6,  4, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 0, 1'b0, 32'h0);
        run_instr(32'h084, 32'd7,  4, 32'h3400_0030, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 0, 1'b0, 32'h0);
        run_instr(32'h0C0, 32'd8,  4, 32'h0000_0077, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 0, 1'b0, 32'h0);
        run_instr(32'h0C4, 32'd9,  4, 32'h3800_0030, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 0, 1'b0, 32'h0);
        run_instr(32'h0C8, 32'd10, 4, 32'h2C00_0008, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 0, 1'b0, 32'h0);
        run_instr(32'h020, 32'd11, 4, 32'h3000_0005, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 0, 1'b1, 32'h24);
        run_instr(32'h014, 32'd12, 4, 32'h2800_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100, 0, 1'b0, 32'h0);
        run_instr(32'h100, 32'd13, 4, 32'h0400_0001, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 5, 1'b0, 32'h0);
        run_instr(32'h104, 32'd14, 9, 32'hFC00_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 0, 1'b0, 32'h0);

        // Halt must absorb even when memory and execute keep signalling.
        @(posedge clk); #1;
        exec_done = 1'b1; imem_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("halt_halted", {31'd0, halted}, 32'd1);
            chk("halt_req", {31'd0, imem_req}, 32'd0);
            chk("halt_retired", retired, 32'd14);
            chk("halt_addr", imem_addr, 32'h104);
        end
        exec_done = 1'b0; imem_valid = 1'b0;

        // Reset out of HALT, then abort a bl in WAIT_EXEC.
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        fetch_issue(32'h000, 32'd0, 0, 32'h3000_0005, 0);
        rst = 1'b1; exec_done = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0; exec_done = 1'b0;
        @(negedge clk);
        chk("abort_addr", imem_addr, 32'h0);
        chk("abort_retired", retired, 32'd0);
        chk("abort_halted", {31'd0, halted}, 32'd0);
        run_instr(32'h000, 32'd0, 0, 32'h0000_0042, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 0, 1'b0, 32'h0);
        f.addr = 32'h004; f.ret = 32'd1; f.gap = 4;
        fq.push_back(f);
        wait_req();
        @(negedge clk);
        @(negedge clk);

        chk("fetch_q_drained", 32'(fq.size()), 32'd0);
        chk("issue_q_drained", 32'(iq.size()), 32'd0);
        chk("link_q_drained", 32'(lq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
